result_mux_pipe: RTL and testbench
==================================

# result_mux_pipe

Parametrised, handshaked result-select stage that sits at the back of the ALU. Combines N_UNITS functional-unit result channels (add, bool, shift, …) of WIDTH bits into one output stream. Selection is one-hot: each unit raises its own valid, and the selected data are OR-combined. The block adds a DEPTH-entry output FIFO with valid/ready backpressure, plus multi-hot collision detection (sticky flag and saturating counter).

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of the output
- N_UNITS, 3, number of result channels (≥2)
- DEPTH, 2, output FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  N_UNITS  per-unit result valid; bit i selects channel i
- in_data  input  N_UNITS×WIDTH (unpacked array [N_UNITS-1:0] of WIDTH)  per-unit result data
- in_ready  output  1  shared by all units; 1 when FIFO count < DEPTH
- out_valid  output  1  FIFO non-empty
- out_data  output  WIDTH  FIFO head entry
- out_ready  input  1  downstream accepts head this cycle
- err_clr  input  1  clears err_multi and err_count
- err_multi  output  1  sticky: a multi-hot select was accepted
- err_count  output  16  accepted multi-hot events, saturating at 16'hFFFF

## Operation
- Accept: a push occurs when in_ready=1 and |in_valid=1.
- Pushed word = OR over i of (in_valid[i] ? in_data[i] : 0).
- Multi-hot on an accepted push (popcount(in_valid) ≥ 2):
  - word still pushed with its OR value
  - err_multi set
  - err_count incremented unless already 16'hFFFF
- Multi-hot while in_ready=0: no push, no error.
- Pop: occurs when out_valid=1 and out_ready=1; head advances.
- in_ready = (count < DEPTH). It depends only on registered count, with no combinational path from out_ready.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- err_clr and a new accepted multi-hot in the same cycle: result is err_multi=1, err_count=1.
- err_clr alone: err_multi=0, err_count=0 next cycle.

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, out_valid=0, out_data=0, err_multi=0, err_count=0.
- in_ready reads 1 during reset, but no transfer occurs while rst_n is low.
- Reset mid-operation drops all FIFO contents immediately; no partial pop.
- Latency: word pushed at edge k → out_valid=1 with that word after edge k (visible in cycle k+1).
- Throughput: one word/cycle sustained while out_ready=1; with DEPTH≥2 in_ready never drops.
- Stall: with out_ready=0, exactly DEPTH pushes are accepted, then in_ready=0.
  - in_ready returns to 1 in the cycle after the first pop.
- out_data stable while out_valid=1 and out_ready=0.
- out_data undefined-free: holds 0 after reset, then last head value when empty (no X).

## Structure
- Package result_mux_pkg:
  - default values for WIDTH, N_UNITS, DEPTH
  - ERR_CNT_W=16 and ERR_CNT_MAX constants
  - onehot_ok(vec) helper function: returns 1 for zero-hot or one-hot
- Sub-module result_fifo:
  - parametrised WIDTH/DEPTH synchronous FIFO
  - push/pop/full/empty/count
  - async active-low reset
- The top level holds only the OR-combine, the error logic and the handshake glue.

## Test plan
- Single-hot stream: in_valid=3'b001 data 32'h0000_0011, then 3'b010 data 32'h0000_0022, then 3'b100 data 32'h0000_0044; out_ready=1 → out_data 11, 22, 44 on consecutive cycles, one cycle after each push; err_multi=0.
- Multi-hot: in_valid=3'b011, in_data[0]=32'h0F00, in_data[1]=32'h00F0 → out_data=32'h0FF0, err_multi=1, err_count=1; err_clr pulse → both 0.
- Backpressure: out_ready=0, push 3 single-hot words → first 2 accepted, in_ready=0 on third; raise out_ready → words drain in order; third accepted the cycle after the first pop.
- Simultaneous push/pop at count=1 for 20 cycles → count stays 1, in_ready stays 1, no word lost or duplicated.
- Counter saturation: force 65 537 accepted multi-hot pushes → err_count=16'hFFFF and stays there. Same-cycle err_clr + multi-hot → err_count=1.
- Reset mid-stall: FIFO full, assert rst_n=0 asynchronously mid-cycle → out_valid=0, out_data=0 immediately; after release, first push appears one cycle later.

Source files
------------

// File: rtl/result_mux_pkg.sv
// rtl/result_mux_pkg.sv - shared defaults, error-counter constants and select helper
package result_mux_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_N_UNITS = 3;
  localparam int DEF_DEPTH   = 2;
  localparam int ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  localparam int MAX_UNITS   = 32;

  // Clearing the lowest set bit leaves zero only for zero-hot or one-hot vectors.
  function automatic logic onehot_ok(input logic [MAX_UNITS-1:0] vec);
    return (vec & (vec - MAX_UNITS'(1))) == '0;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO with registered head word
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = head_q;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    head_d   = head_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
    // Head is registered so it keeps the last shown word once the FIFO drains.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/result_mux_pipe.sv
// rtl/result_mux_pipe.sv - one-hot OR-combine of unit results into a buffered stream
module result_mux_pipe
  import result_mux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_UNITS = DEF_N_UNITS,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_UNITS-1:0]   in_valid,
  input  logic [WIDTH-1:0]     in_data [N_UNITS-1:0],
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 err_multi,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]     word;
  logic                 push, pop, multi_hot;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 err_multi_q, err_multi_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    word = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (in_valid[i]) begin
        word = word | in_data[i];
      end
    end
  end

  assign in_ready  = (fifo_count < CNT_W'(DEPTH));
  assign push      = !fifo_full && (|in_valid);
  assign pop       = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  assign multi_hot = push && !onehot_ok(MAX_UNITS'(in_valid));

  result_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(word),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_data(out_data)
  );

  // A clear coinciding with a new collision still records that collision.
  always_comb begin
    err_multi_d = err_multi_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_multi_d = 1'b0;
      err_count_d = '0;
    end
    if (multi_hot) begin
      err_multi_d = 1'b1;
      if (err_count_d != ERR_CNT_MAX) begin
        err_count_d = err_count_d + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_multi_q <= err_multi_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_multi = err_multi_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_result_mux_pipe.sv
// tb/tb_result_mux_pipe.sv - scoreboard bench for result_mux_pipe
module tb_result_mux_pipe;
  localparam int WIDTH   = 32;
  localparam int N_UNITS = 3;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_UNITS-1:0] in_valid = '0;
  logic [WIDTH-1:0]   in_data [N_UNITS-1:0];
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready = 1'b0;
  logic               err_clr = 1'b0;
  logic               err_multi;
  logic [15:0]        err_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               exp_err = 0;
  int               exp_cnt = 0;
  bit               hold_v = 0;
  logic [WIDTH-1:0] hold_d;

  result_mux_pipe #(.WIDTH(WIDTH), .N_UNITS(N_UNITS), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .err_clr  (err_clr),
    .err_multi(err_multi),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Reference: FIFO occupancy is the queue length; the word is the OR of selected data.
  always @(negedge clk) begin
    bit               acc;
    logic [WIDTH-1:0] w;
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("err_multi", 32'(err_multi), 32'(exp_err));
      check("err_count", 32'(err_count), exp_cnt);
      if (hold_v && out_valid) check("out_data_stable", out_data, hold_d);
      acc = (exp_q.size() < DEPTH) && (in_valid != '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_pop", 32'(1), 32'(0));
        else check("out_data", out_data, exp_q.pop_front());
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (acc) begin
        w = '0;
        for (int i = 0; i < N_UNITS; i++) if (in_valid[i]) w = w | in_data[i];
        exp_q.push_back(w);
      end
      if (err_clr) begin
        exp_err = 0;
        exp_cnt = 0;
      end
      if (acc && $countones(in_valid) >= 2) begin
        exp_err = 1;
        if (exp_cnt < 65535) exp_cnt++;
      end
    end else begin
      hold_v = 0;
    end
  end

  task automatic step(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic ordy, input logic clr);
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    out_ready  = ordy;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(3'b000, 0, 0, 0, 1'b1, 1'b0);
    check("drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    in_data[2] = '0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", out_data, 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_err", {15'd0, err_multi, err_count}, 32'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single-hot stream, one cycle latency
    step(3'b001, 32'h11, 32'hdead, 32'hbeef, 1'b1, 1'b0);
    check("lat_11", out_data, 32'h11);
    step(3'b010, 32'hdead, 32'h22, 32'hbeef, 1'b1, 1'b0);
    check("lat_22", out_data, 32'h22);
    step(3'b100, 32'hdead, 32'hbeef, 32'h44, 1'b1, 1'b0);
    check("lat_44", out_data, 32'h44);
    check("single_no_err", 32'(err_multi), 32'(0));
    drain();

    // multi-hot collision and clear
    step(3'b011, 32'h0F00, 32'h00F0, 32'h1234, 1'b0, 1'b0);
    check("multi_data", out_data, 32'h0FF0);
    check("multi_err", 32'(err_multi), 32'(1));
    check("multi_cnt", 32'(err_count), 32'(1));
    step(3'b000, 0, 0, 0, 1'b1, 1'b1);
    check("clr_err", 32'(err_multi), 32'(0));
    check("clr_cnt", 32'(err_count), 32'(0));
    drain();

    // backpressure
    step(3'b001, 32'hA1, 0, 0, 1'b0, 1'b0);
    step(3'b010, 0, 32'hA2, 0, 1'b0, 1'b0);
    check("bp_full", 32'(in_ready), 32'(0));
    step(3'b100, 0, 0, 32'hA3, 1'b0, 1'b0);
    check("bp_still_full", 32'(in_ready), 32'(0));
    step(3'b100, 0, 0, 32'hA3, 1'b1, 1'b0);
    check("bp_reopen", 32'(in_ready), 32'(1));
    step(3'b100, 0, 0, 32'hA3, 1'b1, 1'b0);
    drain();

    // simultaneous push/pop at count 1
    step(3'b001, 32'h500, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(3'(1) << $urandom_range(0, 2), $urandom, $urandom, $urandom, 1'b1, 1'b0);
      check("pp_ready", 32'(in_ready), 32'(1));
      check("pp_count1", 32'(exp_q.size()), 32'(1));
    end
    drain();

    // counter saturation
    for (int i = 0; i < 65537; i++) step(3'b011, $urandom, $urandom, 0, 1'b1, 1'b0);
    check("sat_cnt", 32'(err_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) step(3'b110, 0, $urandom, $urandom, 1'b1, 1'b0);
    check("sat_hold", 32'(err_count), 32'hFFFF);
    step(3'b101, 32'h1, 0, 32'h2, 1'b1, 1'b1);
    check("clr_plus_multi_cnt", 32'(err_count), 32'(1));
    check("clr_plus_multi_err", 32'(err_multi), 32'(1));
    step(3'b000, 0, 0, 0, 1'b1, 1'b1);
    drain();

    // reset while full and stalled
    step(3'b001, 32'hC1, 0, 0, 1'b0, 1'b0);
    step(3'b010, 0, 32'hC2, 0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_err = 0;
    exp_cnt = 0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_out_data", out_data, 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    in_valid = 3'b001;
    @(posedge clk);
    in_valid = 3'b000;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_empty", 32'(out_valid), 32'(0));
    step(3'b001, 32'h55, 0, 0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'(1));
    check("post_rst_data", out_data, 32'h55);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
